// File: rtl/ppfifo_sync_pingpong.sv
// ppfifo_sync_pingpong
//   Single-clock ping-pong FIFO. The writer fills one of two buffers at a time
//   through a one-hot activate handshake. Each committed buffer is handed to the
//   reader in commit order. The reader is given a word count first and then
//   pulls the words with strobes.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active low
//   o_write_ready    [1:0] buffer i is empty and free for the writer
//   i_write_activate [1:0] one-hot, the writer owns buffer i while bit i is high
//   o_write_size     buffer depth in words (constant)
//   i_write_stb      store i_write_data into the active write buffer
//   i_write_data     write data
//   o_read_ready     a committed buffer is waiting for the reader
//   i_read_activate  the reader owns the head buffer while this is high
//   o_read_size      word count of the head buffer
//   i_read_stb       consume the current o_read_data and advance
//   o_read_data      current word of the active read buffer
//   o_overflow       sticky: dropped write strobe or conflicting activate
//   o_underflow      sticky: read strobe with nothing left to read
module ppfifo_sync_pingpong #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [1:0]            o_write_ready,
   input  logic [1:0]            i_write_activate,
   output logic [23:0]           o_write_size,
   input  logic                  i_write_stb,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   output logic                  o_read_ready,
   input  logic                  i_read_activate,
   output logic [23:0]           o_read_size,
   input  logic                  i_read_stb,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
   localparam int unsigned CntW  = ADDRESS_WIDTH + 1;

   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t DepthC = cnt_t'(Depth);

   typedef enum logic [1:0] {StEmpty, StWriting, StFull, StReading} buf_st_e;

   // Buffer index is the address MSB.
   logic [DATA_WIDTH-1:0] mem [2*Depth];

   buf_st_e st_q [2];
   buf_st_e st_d [2];
   cnt_t    size_q [2];
   cnt_t    size_d [2];
   cnt_t    wr_cnt_q, wr_cnt_d;
   cnt_t    rd_ptr_q, rd_ptr_d;
   // Commit-order queue: bit 0 is the head, ord_n_q holds the entry count.
   logic [1:0] ord_q, ord_d;
   logic [1:0] ord_n_q, ord_n_d;
   logic [1:0] wr_ready_q, wr_ready_d;
   logic       rd_ready_q, rd_ready_d;
   cnt_t       rd_size_q, rd_size_d;
   logic       ovf_q, ovf_d;
   logic       unf_q, unf_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic                   wr_en;
   logic [ADDRESS_WIDTH:0] wr_addr;
   logic                   rd_load;
   logic [ADDRESS_WIDTH:0] rd_addr;
   logic                   wr_idx;
   logic                   wr_busy;
   cnt_t                   cnt_inc;
   logic                   push;
   logic [1:0]             take;
   logic                   head;
   logic                   has_head;
   logic                   reading;
   logic                   rd_take;
   logic                   rd_rel;
   cnt_t                   nxt_ptr;

   always_comb begin
      st_d       = st_q;
      size_d     = size_q;
      wr_cnt_d   = wr_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      ord_d      = ord_q;
      ord_n_d    = ord_n_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      wr_en      = 1'b0;
      rd_load    = 1'b0;
      rd_addr    = '0;
      push       = 1'b0;
      take       = 2'b00;

      // ---------------- write side ----------------
      // At most one buffer is ever in StWriting.
      wr_idx  = (st_q[1] == StWriting);
      wr_busy = (st_q[wr_idx] == StWriting);
      wr_addr = {wr_idx, wr_cnt_q[ADDRESS_WIDTH-1:0]};
      cnt_inc = wr_cnt_q;
      if (i_write_stb) begin
         if (wr_busy && (wr_cnt_q < DepthC)) begin
            wr_en   = 1'b1;
            cnt_inc = wr_cnt_q + cnt_t'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
      wr_cnt_d = cnt_inc;

      // Writer releases its buffer: commit if anything was written.
      if (wr_busy && !i_write_activate[wr_idx]) begin
         if (cnt_inc != '0) begin
            st_d[wr_idx]   = StFull;
            size_d[wr_idx] = cnt_inc;
            push           = 1'b1;
         end else begin
            st_d[wr_idx] = StEmpty;
         end
      end

      // A buffer can be taken only when the other one is not being held for writing.
      take[0] = i_write_activate[0] && wr_ready_q[0] && (st_q[0] == StEmpty) &&
                !((st_q[1] == StWriting) && i_write_activate[1]);
      take[1] = i_write_activate[1] && wr_ready_q[1] && (st_q[1] == StEmpty) &&
                !((st_q[0] == StWriting) && i_write_activate[0]);
      if (take == 2'b11) begin
         take[1] = 1'b0;
         ovf_d   = 1'b1;
      end
      if (take[0]) begin
         st_d[0]  = StWriting;
         wr_cnt_d = '0;
      end
      if (take[1]) begin
         st_d[1]  = StWriting;
         wr_cnt_d = '0;
      end

      // ---------------- read side ----------------
      head     = ord_q[0];
      has_head = (ord_n_q != 2'd0);
      reading  = has_head && (st_q[head] == StReading);
      rd_take  = i_read_activate && rd_ready_q && has_head && (st_q[head] == StFull);
      rd_rel   = reading && !i_read_activate;
      nxt_ptr  = rd_ptr_q + cnt_t'(1);

      if (rd_take) begin
         st_d[head] = StReading;
         rd_ptr_d   = '0;
         rd_load    = 1'b1;
         rd_addr    = {head, {ADDRESS_WIDTH{1'b0}}};
      end else if (reading && i_read_stb) begin
         if (rd_ptr_q == size_q[head]) begin
            unf_d = 1'b1;
         end else begin
            rd_ptr_d = nxt_ptr;
            // Past the last word the output keeps showing the last word.
            if (nxt_ptr < size_q[head]) begin
               rd_load = 1'b1;
               rd_addr = {head, nxt_ptr[ADDRESS_WIDTH-1:0]};
            end
         end
      end else if (i_read_stb) begin
         unf_d = 1'b1;
      end

      if (rd_rel) begin
         st_d[head] = StEmpty;
      end

      // Queue pop happens before push so a same-cycle commit lands in the right slot.
      if (rd_rel) begin
         ord_d[0] = ord_q[1];
         ord_n_d  = ord_n_q - 2'd1;
      end
      if (push) begin
         if (ord_n_d == 2'd0) begin
            ord_d[0] = wr_idx;
         end else begin
            ord_d[1] = wr_idx;
         end
         ord_n_d = ord_n_d + 2'd1;
      end

      // ---------------- registered handshake outputs ----------------
      wr_ready_d[0] = (st_d[0] == StEmpty) && !i_write_activate[0];
      wr_ready_d[1] = (st_d[1] == StEmpty) && !i_write_activate[1];
      // Built from current state so a freed buffer reports write-ready one cycle
      // before the next head reports read-ready.
      rd_ready_d    = has_head && (st_q[head] == StFull) && !i_read_activate;
      rd_size_d     = has_head ? size_q[head] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q[0]    <= StEmpty;
         st_q[1]    <= StEmpty;
         size_q[0]  <= '0;
         size_q[1]  <= '0;
         wr_cnt_q   <= '0;
         rd_ptr_q   <= '0;
         ord_q      <= '0;
         ord_n_q    <= '0;
         wr_ready_q <= '0;
         rd_ready_q <= 1'b0;
         rd_size_q  <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         st_q       <= st_d;
         size_q     <= size_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         ord_q      <= ord_d;
         ord_n_q    <= ord_n_d;
         wr_ready_q <= wr_ready_d;
         rd_ready_q <= rd_ready_d;
         rd_size_q  <= rd_size_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         if (rd_load) begin
            rd_data_q <= mem[rd_addr];
         end
      end
   end

   // Storage has no reset; its contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= i_write_data;
      end
   end

   assign o_write_ready = wr_ready_q;
   assign o_write_size  = 24'(Depth);
   assign o_read_ready  = rd_ready_q;
   assign o_read_size   = 24'(rd_size_q);
   assign o_read_data   = rd_data_q;
   assign o_overflow    = ovf_q;
   assign o_underflow   = unf_q;

endmodule

// File: tb/tb_ppfifo_sync_pingpong.sv
module tb_ppfifo_sync_pingpong;

   logic        clk;
   logic        rst;
   logic [1:0]  o_write_ready;
   logic [1:0]  wact;
   logic [23:0] o_write_size;
   logic        wstb;
   logic [31:0] wdata;
   logic        o_read_ready;
   logic        ract;
   logic [23:0] o_read_size;
   logic        rstb;
   logic [31:0] o_read_data;
   logic        o_overflow;
   logic        o_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   ppfifo_sync_pingpong #(
      .DATA_WIDTH   (32),
      .ADDRESS_WIDTH(9)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .o_write_ready   (o_write_ready),
      .i_write_activate(wact),
      .o_write_size    (o_write_size),
      .i_write_stb     (wstb),
      .i_write_data    (wdata),
      .o_read_ready    (o_read_ready),
      .i_read_activate (ract),
      .o_read_size     (o_read_size),
      .i_read_stb      (rstb),
      .o_read_data     (o_read_data),
      .o_overflow      (o_overflow),
      .o_underflow     (o_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled and inputs changed 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_buf(input int idx, input int n, input logic [31:0] base);
      wact      = 2'b00;
      wact[idx] = 1'b1;
      tick();
      for (int k = 0; k < n; k++) begin
         wstb  = 1'b1;
         wdata = base + 32'(k);
         tick();
      end
      wstb = 1'b0;
      wact = 2'b00;
      tick();
   endtask

   initial begin
      rst   = 1'b0;
      wact  = 2'b00;
      wstb  = 1'b0;
      wdata = '0;
      ract  = 1'b0;
      rstb  = 1'b0;
      #2;
      // ---- 1: reset state and release ----
      chk("rst_wready", 32'(o_write_ready), 32'h0);
      chk("rst_rready", 32'(o_read_ready), 32'h0);
      chk("rst_wsize", 32'(o_write_size), 32'd512);
      chk("rst_rsize", 32'(o_read_size), 32'h0);
      chk("rst_ovf", 32'(o_overflow), 32'h0);
      tick();
      rst = 1'b1;
      tick();
      chk("rel_wready", 32'(o_write_ready), 32'h3);
      chk("rel_rready", 32'(o_read_ready), 32'h0);
      chk("rel_wsize", 32'(o_write_size), 32'd512);

      // ---- 2: single buffer round trip ----
      write_buf(0, 4, 32'hA0);
      chk("t2_wready_commit", 32'(o_write_ready), 32'h2);
      chk("t2_rready_early", 32'(o_read_ready), 32'h0);
      tick();
      chk("t2_rready", 32'(o_read_ready), 32'h1);
      chk("t2_rsize", 32'(o_read_size), 32'd4);
      ract = 1'b1;
      tick();
      chk("t2_rready_drop", 32'(o_read_ready), 32'h0);
      chk("t2_w0", o_read_data, 32'hA0);
      rstb = 1'b1;
      tick();
      chk("t2_w1", o_read_data, 32'hA1);
      tick();
      chk("t2_w2", o_read_data, 32'hA2);
      tick();
      chk("t2_w3", o_read_data, 32'hA3);
      tick();
      chk("t2_hold_last", o_read_data, 32'hA3);
      chk("t2_unf", 32'(o_underflow), 32'h0);
      rstb = 1'b0;
      ract = 1'b0;
      tick();
      chk("t2_wready_back", 32'(o_write_ready), 32'h3);

      // ---- 3: commit order beats index order ----
      write_buf(1, 3, 32'hB0);
      write_buf(0, 2, 32'hC0);
      chk("t3_wready", 32'(o_write_ready), 32'h0);
      chk("t3_rready", 32'(o_read_ready), 32'h1);
      chk("t3_rsize_first", 32'(o_read_size), 32'd3);
      ract = 1'b1;
      tick();
      chk("t3_b0", o_read_data, 32'hB0);
      rstb = 1'b1;
      tick();
      chk("t3_b1", o_read_data, 32'hB1);
      tick();
      chk("t3_b2", o_read_data, 32'hB2);
      rstb = 1'b0;
      ract = 1'b0;
      tick();
      chk("t3_wready_b1", 32'(o_write_ready), 32'h2);
      chk("t3_rready_gap", 32'(o_read_ready), 32'h0);
      tick();
      chk("t3_rready_second", 32'(o_read_ready), 32'h1);
      chk("t3_rsize_second", 32'(o_read_size), 32'd2);
      ract = 1'b1;
      tick();
      chk("t3_c0", o_read_data, 32'hC0);
      rstb = 1'b1;
      tick();
      chk("t3_c1", o_read_data, 32'hC1);
      rstb = 1'b0;
      ract = 1'b0;
      tick();
      chk("t3_wready_all", 32'(o_write_ready), 32'h3);

      // ---- 4: overfill one buffer ----
      wact = 2'b01;
      tick();
      for (int k = 0; k < 512; k++) begin
         wstb  = 1'b1;
         wdata = 32'h400 + 32'(k);
         tick();
      end
      chk("t4_no_ovf_at_full", 32'(o_overflow), 32'h0);
      wdata = 32'hDEAD;
      tick();
      chk("t4_ovf", 32'(o_overflow), 32'h1);
      wstb = 1'b0;
      wact = 2'b00;
      tick();
      tick();
      chk("t4_rready", 32'(o_read_ready), 32'h1);
      chk("t4_rsize", 32'(o_read_size), 32'd512);
      ract = 1'b1;
      tick();
      chk("t4_word0", o_read_data, 32'h400);
      rstb = 1'b1;
      for (int k = 0; k < 511; k++) begin
         tick();
      end
      rstb = 1'b0;
      chk("t4_word511", o_read_data, 32'h5FF);
      ract = 1'b0;
      tick();

      // ---- 5: empty activate cycle ----
      wact = 2'b10;
      tick();
      chk("t5_wready_taken", 32'(o_write_ready), 32'h1);
      wact = 2'b00;
      tick();
      chk("t5_wready_back", 32'(o_write_ready), 32'h3);
      tick();
      chk("t5_no_rready", 32'(o_read_ready), 32'h0);

      // ---- 6: early read release, underflow, reset mid-write ----
      write_buf(1, 4, 32'hD0);
      tick();
      chk("t6_rsize4", 32'(o_read_size), 32'd4);
      ract = 1'b1;
      tick();
      rstb = 1'b1;
      tick();
      tick();
      chk("t6_d2", o_read_data, 32'hD2);
      rstb = 1'b0;
      ract = 1'b0;
      tick();
      chk("t6_early_rel_wready", 32'(o_write_ready), 32'h3);
      tick();
      chk("t6_early_rel_rready", 32'(o_read_ready), 32'h0);

      write_buf(0, 1, 32'hE0);
      tick();
      chk("t6_rsize1", 32'(o_read_size), 32'd1);
      ract = 1'b1;
      tick();
      chk("t6_e0", o_read_data, 32'hE0);
      rstb = 1'b1;
      tick();
      chk("t6_unf_none", 32'(o_underflow), 32'h0);
      chk("t6_e0_hold", o_read_data, 32'hE0);
      tick();
      chk("t6_unf", 32'(o_underflow), 32'h1);
      chk("t6_e0_hold2", o_read_data, 32'hE0);
      rstb = 1'b0;
      ract = 1'b0;
      tick();

      wact = 2'b01;
      tick();
      wstb  = 1'b1;
      wdata = 32'hF0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("t6_mid_wready", 32'(o_write_ready), 32'h0);
      chk("t6_mid_rready", 32'(o_read_ready), 32'h0);
      chk("t6_mid_rsize", 32'(o_read_size), 32'h0);
      chk("t6_mid_rdata", o_read_data, 32'h0);
      chk("t6_mid_ovf", 32'(o_overflow), 32'h0);
      chk("t6_mid_unf", 32'(o_underflow), 32'h0);
      chk("t6_mid_wsize", 32'(o_write_size), 32'd512);
      wstb = 1'b0;
      wact = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      chk("t6_after_wready", 32'(o_write_ready), 32'h3);
      tick();
      chk("t6_after_rready", 32'(o_read_ready), 32'h0);

      // ---- both activate bits at once: bit 0 wins, overflow flagged ----
      wact = 2'b11;
      tick();
      chk("dual_ovf", 32'(o_overflow), 32'h1);
      chk("dual_wready", 32'(o_write_ready), 32'h0);
      wact = 2'b10;
      tick();
      chk("dual_buf1_not_taken", 32'(o_write_ready), 32'h1);
      wact = 2'b00;
      tick();
      chk("dual_wready_back", 32'(o_write_ready), 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
